// File: rtl/float32_add_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float32_add_pipe_pkg
// Description : Shared Float32 type and constants for the pipelined adder.
//               Provides the Float32 field layout plus the widths of the
//               internal aligned significand and raw sum.
// Revision    : 1.0 - initial release
// ============================================================================
package float32_add_pipe_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float32_t;

    localparam int FLOAT32_BIAS      = 127;
    localparam int FLOAT32_EXP_MAX   = 255;
    localparam int FLOAT32_SIG_WIDTH = 24;

    // Significand with implicit 1 plus two guard bits below the LSB
    localparam int c_ALIGN_WIDTH = FLOAT32_SIG_WIDTH + 2;
    // Aligned sum including the carry-out bit
    localparam int c_SUM_WIDTH   = c_ALIGN_WIDTH + 1;

endpackage : float32_add_pipe_pkg
`default_nettype wire

// File: rtl/float32_add_pipe_lead_zero_count.sv
`default_nettype none
// ============================================================================
// Module      : lead_zero_count
// Description : Combinational leading-zero counter over the 27-bit raw sum.
//               An all-zero input reports 27.
// Ports       : i_value [26:0] - value to scan
//               o_count [4:0]  - number of zeros above the most significant 1
// Revision    : 1.0 - initial release
// ============================================================================
module lead_zero_count
    import float32_add_pipe_pkg::*;
(
    input  logic [c_SUM_WIDTH-1:0] i_value,
    output logic [4:0]             o_count
);

    // Scanning upward leaves the count of the highest set bit as the final value
    always_comb begin
        o_count = 5'(c_SUM_WIDTH);
        for (int i = 0; i < c_SUM_WIDTH; i++) begin
            if (i_value[i]) begin
                o_count = 5'(c_SUM_WIDTH - 1 - i);
            end
        end
    end

endmodule : lead_zero_count
`default_nettype wire

// File: rtl/float32_add_pipe.sv
`default_nettype none
// ============================================================================
// Module      : float32_add_pipe
// Description : Three-stage pipelined Float32 adder/subtractor with
//               valid/ready handshake. Truncating rounding, denormals
//               flushed to zero, exponent 255 forces infinity.
// Ports       : aClock, aReset        - clock, synchronous active-high reset
//               anInValid/anInReady   - input handshake
//               anInputA, anInputB    - Float32 operands
//               aSubtract             - 1: A - B
//               anOutValid/anOutReady - output handshake
//               anOutput              - Float32 result
// Revision    : 1.0 - initial release
// ============================================================================
module float32_add_pipe
    import float32_add_pipe_pkg::*;
(
    input  logic        aClock,
    input  logic        aReset,
    input  logic        anInValid,
    output logic        anInReady,
    input  logic [31:0] anInputA,
    input  logic [31:0] anInputB,
    input  logic        aSubtract,
    output logic        anOutValid,
    input  logic        anOutReady,
    output logic [31:0] anOutput
);

    typedef struct packed {
        logic                     special;
        logic                     special_sign;
        logic                     neg_zero;
        logic                     eff_sub;
        logic                     sign;
        logic [7:0]               exp;
        logic [c_ALIGN_WIDTH-1:0] large_sig;
        logic [c_ALIGN_WIDTH-1:0] small_sig;
        logic [7:0]               shift;
    } s1_t;

    typedef struct packed {
        logic                   special;
        logic                   special_sign;
        logic                   neg_zero;
        logic                   sign;
        logic [7:0]             exp;
        logic [c_SUM_WIDTH-1:0] sum;
    } s2_t;

    logic     w_advance;
    logic     r_v1, r_v2, r_v3;
    s1_t      r_s1, w_s1;
    s2_t      r_s2, w_s2;
    float32_t r_out, w_out;

    assign w_advance  = !r_v3 || anOutReady;
    assign anInReady  = w_advance;
    assign anOutValid = r_v3;
    assign anOutput   = r_out;

    // ---------------- Stage 1: classify / order by magnitude ----------------
    float32_t    w_a, w_b;
    logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_swap;
    logic [30:0] w_a_mag, w_b_mag;

    always_comb begin
        w_a      = anInputA;
        w_b      = anInputB;
        w_b.sign = anInputB[31] ^ aSubtract;
        w_a_zero = (w_a.exponent == 8'd0);
        w_b_zero = (w_b.exponent == 8'd0);
        w_a_inf  = (w_a.exponent == 8'(FLOAT32_EXP_MAX));
        w_b_inf  = (w_b.exponent == 8'(FLOAT32_EXP_MAX));
        // Flushed operands compare as magnitude zero
        w_a_mag  = w_a_zero ? 31'd0 : {w_a.exponent, w_a.mantissa};
        w_b_mag  = w_b_zero ? 31'd0 : {w_b.exponent, w_b.mantissa};
        w_swap   = (w_b_mag > w_a_mag);

        w_s1              = '0;
        w_s1.special      = w_a_inf || w_b_inf;
        w_s1.special_sign = w_a_inf ? w_a.sign : w_b.sign;
        w_s1.neg_zero     = w_a_zero && w_b_zero && w_a.sign && w_b.sign;
        w_s1.eff_sub      = (w_a.sign != w_b.sign);
        w_s1.sign         = w_swap ? w_b.sign : w_a.sign;
        w_s1.exp          = w_swap ? w_b.exponent : w_a.exponent;
        w_s1.shift        = w_swap ? (w_b.exponent - w_a.exponent)
                                   : (w_a.exponent - w_b.exponent);
        w_s1.large_sig    = w_swap ? (w_b_zero ? '0 : {1'b1, w_b.mantissa, 2'b00})
                                   : (w_a_zero ? '0 : {1'b1, w_a.mantissa, 2'b00});
        w_s1.small_sig    = w_swap ? (w_a_zero ? '0 : {1'b1, w_a.mantissa, 2'b00})
                                   : (w_b_zero ? '0 : {1'b1, w_b.mantissa, 2'b00});
    end

    // ---------------- Stage 2: align and add/subtract -----------------------
    logic [c_ALIGN_WIDTH-1:0] w_small_aligned;

    always_comb begin
        w_small_aligned = (r_s1.shift >= 8'(c_ALIGN_WIDTH)) ? '0
                                                             : (r_s1.small_sig >> r_s1.shift);
        w_s2              = '0;
        w_s2.special      = r_s1.special;
        w_s2.special_sign = r_s1.special_sign;
        w_s2.neg_zero     = r_s1.neg_zero;
        w_s2.sign         = r_s1.sign;
        w_s2.exp          = r_s1.exp;
        // Large operand has the larger magnitude, so the difference never wraps
        w_s2.sum          = r_s1.eff_sub ? ({1'b0, r_s1.large_sig} - {1'b0, w_small_aligned})
                                         : ({1'b0, r_s1.large_sig} + {1'b0, w_small_aligned});
    end

    // ---------------- Stage 3: normalize and pack ---------------------------
    logic [4:0]             w_lzc;
    logic [c_SUM_WIDTH-1:0] w_norm;
    logic signed [9:0]      w_exp;
    logic [22:0]            w_mant;

    lead_zero_count u_lzc (
        .i_value (r_s2.sum),
        .o_count (w_lzc)
    );

    // Shifting by the count puts the leading 1 at bit 26. A carry-out has
    // count 0 (exponent +1); the normal position (bit 25) has count 1.
    always_comb begin
        w_norm = r_s2.sum << w_lzc;
        w_mant = 23'(w_norm >> 3);
        w_exp  = signed'({2'b00, r_s2.exp}) + 10'sd1 - signed'({5'b00000, w_lzc});
        w_out  = '0;
        if (r_s2.special) begin
            w_out = {r_s2.special_sign, 8'hFF, 23'd0};
        end else if (r_s2.sum == '0) begin
            w_out = {r_s2.neg_zero, 31'd0};
        end else if (w_exp >= 10'sd255) begin
            w_out = {r_s2.sign, 8'hFF, 23'd0};
        end else if (w_exp <= 10'sd0) begin
            w_out = {r_s2.sign, 31'd0};
        end else begin
            w_out = {r_s2.sign, w_exp[7:0], w_mant};
        end
    end

    // ---------------- Pipeline registers -----------------------------------
    always_ff @(posedge aClock) begin
        if (aReset) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_s1  <= '0;
            r_s2  <= '0;
            r_out <= '0;
        end else if (w_advance) begin
            r_v1  <= anInValid;
            r_v2  <= r_v1;
            r_v3  <= r_v2;
            r_s1  <= w_s1;
            r_s2  <= w_s2;
            r_out <= w_out;
        end
    end

endmodule : float32_add_pipe
`default_nettype wire

// File: tb/tb_float32_add_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_float32_add_pipe
// Description : Directed self-checking bench for float32_add_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float32_add_pipe;

    logic        aClock = 1'b0;
    logic        aReset;
    logic        anInValid;
    logic        anInReady;
    logic [31:0] anInputA;
    logic [31:0] anInputB;
    logic        aSubtract;
    logic        anOutValid;
    logic        anOutReady;
    logic [31:0] anOutput;

    int n_checks = 0;
    int n_errors = 0;

    always #5 aClock = ~aClock;

    float32_add_pipe u_dut (
        .aClock     (aClock),
        .aReset     (aReset),
        .anInValid  (anInValid),
        .anInReady  (anInReady),
        .anInputA   (anInputA),
        .anInputB   (anInputB),
        .aSubtract  (aSubtract),
        .anOutValid (anOutValid),
        .anOutReady (anOutReady),
        .anOutput   (anOutput)
    );

    task automatic tick();
        @(posedge aClock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated operation: accepted at the first edge, result visible
    // after the third edge and not before.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp);
        anInValid = 1'b1;
        anInputA  = a;
        anInputB  = b;
        aSubtract = sub;
        tick();
        anInValid = 1'b0;
        tick();
        check({tag, "_early"}, {31'd0, anOutValid}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'd0, anOutValid}, 32'd1);
        check(tag, anOutput, exp);
        tick();
    endtask

    logic [31:0] pa [6];
    logic [31:0] pb [6];
    logic        ps [6];
    logic [31:0] pe [6];
    int          sent;
    int          recv;

    initial begin
        aReset     = 1'b1;
        anInValid  = 1'b0;
        anInputA   = '0;
        anInputB   = '0;
        aSubtract  = 1'b0;
        anOutReady = 1'b1;
        tick();
        tick();
        aReset = 1'b0;
        check("rst_out_valid", {31'd0, anOutValid}, 32'd0);
        check("rst_output", anOutput, 32'h0000_0000);
        check("rst_in_ready", {31'd0, anInReady}, 32'd1);

        // Directed single operations
        run_op("one_plus_two", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
        run_op("cancel_add",   32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000);
        run_op("cancel_sub",   32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000);
        run_op("overflow",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);
        run_op("inf_a_sign",   32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7F80_0000);
        run_op("inf_b_sub",    32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000);
        run_op("tiny_shift",   32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000);
        run_op("denorm_flush", 32'h0000_0001, 32'h4000_0000, 1'b0, 32'h4000_0000);
        run_op("neg_zeros",    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000);
        run_op("mixed_zeros",  32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000);
        run_op("underflow",    32'h0080_0000, 32'h0080_0001, 1'b1, 32'h8000_0000);
        run_op("eight_m_one",  32'h4100_0000, 32'h3F80_0000, 1'b1, 32'h40E0_0000);

        // Back-to-back stream with output stalled in cycles 4 and 5
        pa[0] = 32'h3F80_0000; pb[0] = 32'h3F80_0000; ps[0] = 1'b0; pe[0] = 32'h4000_0000;
        pa[1] = 32'h4000_0000; pb[1] = 32'h4000_0000; ps[1] = 1'b0; pe[1] = 32'h4080_0000;
        pa[2] = 32'h3F80_0000; pb[2] = 32'h4000_0000; ps[2] = 1'b0; pe[2] = 32'h4040_0000;
        pa[3] = 32'h4100_0000; pb[3] = 32'h3F80_0000; ps[3] = 1'b1; pe[3] = 32'h40E0_0000;
        pa[4] = 32'h3F00_0000; pb[4] = 32'h3E80_0000; ps[4] = 1'b0; pe[4] = 32'h3F40_0000;
        pa[5] = 32'hBF80_0000; pb[5] = 32'hC000_0000; ps[5] = 1'b0; pe[5] = 32'hC040_0000;
        sent = 0;
        recv = 0;
        for (int c = 1; c <= 14; c++) begin
            anOutReady = !(c == 4 || c == 5);
            if (sent < 6) begin
                anInValid = 1'b1;
                anInputA  = pa[sent];
                anInputB  = pb[sent];
                aSubtract = ps[sent];
            end else begin
                anInValid = 1'b0;
            end
            #1;
            if (c <= 8) begin
                check($sformatf("stream_in_ready_c%0d", c), {31'd0, anInReady},
                      (c == 4 || c == 5) ? 32'd0 : 32'd1);
            end
            if (anInValid && anInReady) sent++;
            if (anOutValid && anOutReady) begin
                if (recv < 6) begin
                    check($sformatf("stream_out_%0d", recv), anOutput, pe[recv]);
                end else begin
                    check("stream_extra_out", {31'd0, anOutValid}, 32'd0);
                end
                recv++;
            end
            tick();
        end
        check("stream_recv_count", 32'(recv), 32'd6);
        anOutReady = 1'b1;

        // Reset with three pairs in flight
        for (int k = 0; k < 3; k++) begin
            anInValid = 1'b1;
            anInputA  = pa[k];
            anInputB  = pb[k];
            aSubtract = ps[k];
            tick();
        end
        anInValid = 1'b0;
        aReset    = 1'b1;
        tick();
        aReset = 1'b0;
        check("midrst_out_valid", {31'd0, anOutValid}, 32'd0);
        check("midrst_output", anOutput, 32'h0000_0000);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("midrst_no_stale_%0d", k), {31'd0, anOutValid}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_float32_add_pipe
`default_nettype wire

// File: doc/float32_add_pipe.md
# float32_add_pipe

Three-stage pipelined Float32 adder/subtractor that sits directly downstream of the integer-to-Float32 converter in FPCore and combines converted operands with other Float32 values. Accepts one operand pair per cycle under a valid/ready handshake, stalls the whole pipeline on output backpressure, and produces a Float32 sum. Simplified IEEE-754 behaviour: truncating rounding, denormals flushed to zero, no NaN generation.

## Interface
- No parameters; all widths are fixed by the Float32 type.
- aClock  in  1  sole clock; all state updates on the rising edge.
- aReset  in  1  synchronous, active-high reset.
- anInValid  in  1  operand pair on anInputA/anInputB/aSubtract is valid.
- anInReady  out  1  block accepts the pair this cycle.
- anInputA  in  32 (Float32)  operand A.
- anInputB  in  32 (Float32)  operand B.
- aSubtract  in  1  1: compute A − B (B sign inverted at entry).
- anOutValid  out  1  anOutput holds a result.
- anOutReady  in  1  consumer accepts the result.
- anOutput  out  32 (Float32)  A ± B.

## Operation
- Advance = !anOutValid || anOutReady; anInReady = Advance. Transfer in when anInValid && anInReady; transfer out when anOutValid && anOutReady.
- All three stage registers (valid bit + payload) load together on Advance; on !Advance all hold.
- Stage 1 (classify/swap): operand with exponent 0 is treated as ±0. Exponent 255 on either operand: result forced to exponent 255, mantissa 0, sign of A if A is 255, otherwise sign of B (post-subtract inversion); bypasses arithmetic. Otherwise order operands by magnitude {exponent, mantissa}; shift = larger exp − smaller exp.
- Stage 2 (align/add): significands are 24 bits with implicit 1, extended with 2 low bits (26 bits). Smaller operand shifted right by shift; shift ≥ 26 contributes 0; shifted-out bits discarded. Equal signs: add (27-bit result); differing: larger − smaller.
- Stage 3 (normalize/pack): carry out → shift right 1, exponent +1. Otherwise left-shift by leading-zero count, exponent − count. Result mantissa truncated (round toward zero). Zero sum → 0x00000000 (+0), including exact cancellation. Exponent ≥ 255 → ±infinity (exp 255, mantissa 0). Exponent ≤ 0 → signed zero (sign, exp 0, mantissa 0). Both inputs zero → +0 unless both −0, then −0.

## Timing
- Latency: 3 cycles with anOutReady held high; throughput 1 pair/cycle.
- Reset: all stage valid bits 0; anOutValid = 0; anOutput = 0x00000000; anInReady = 1 on the first cycle after reset.
- Reset mid-operation: all in-flight results discarded, none emitted afterwards.
- anOutput stable while anOutValid && !anOutReady.
- Bubbles (anInValid low) propagate as invalid stages; a bubble in stage 3 does not stall input.
- Simultaneous in and out transfer in the same cycle is legal and required for full throughput.

## Structure
- Shared package (Types): existing Float32 typedef; add constants FLOAT32_BIAS = 127, FLOAT32_EXP_MAX = 255, FLOAT32_SIG_WIDTH = 24.
- Stage payloads as packed structs local to the module.
- One sub-module: lead_zero_count, combinational 27-bit leading-zero counter (5-bit count), used in stage 3.

## Test plan
- 0x3F800000 + 0x40000000 (1.0 + 2.0) → 0x40400000 exactly 3 cycles after acceptance.
- 0x3F800000 + 0xBF800000 → 0x00000000; same with aSubtract=1 on 0x3F800000, 0x3F800000 → 0x00000000.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000; 0x7F800000 + 0xFF800000 → 0x7F800000 (A sign priority).
- 0x3F800000 + 0x30800000 (2^-30) → 0x3F800000; denormal 0x00000001 + 0x40000000 → 0x40000000.
- Back-to-back 6 pairs, anOutReady low for cycles 4–5: anInReady drops exactly those cycles, all 6 results emitted in order, none duplicated or lost.
- aReset asserted with 3 pairs in flight → anOutValid 0 next cycle, no stale result later.
